// File: rtl/btn_pkg.sv
// Shared types, default timing constants and the counter-width helper for the
// pushbutton conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } btn_state_t;

  localparam int DEFAULT_NUM_BTN         = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;
  localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;

  // Returns ceil(log2(value)), never less than 1 so a counter always has a bit.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: 2-FF synchroniser, debounce FSM and registered
// press/release strobes. Auto-repeat is built only when AUTOREPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btnRaw,
  output logic btnLevel,
  output logic btnPress,
  output logic btnRelease
);

  localparam int CntW = clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : gBadParams
    $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
  end

  logic [1:0]      syncFf;
  logic            btnSync;
  btn_state_t      state, nextState;
  logic [CntW-1:0] cnt, nextCnt;
  logic            nextLevel, nextPress, nextRelease;

  assign btnSync = syncFf[1];

`ifdef AUTOREPEAT_EN
  localparam int RptW = clog2((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RptW-1:0] RptDelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] RptPeriodLast = RptW'(REPEAT_PERIOD - 1);

  // rptArmed marks that the first (long) delay has elapsed; later pulses use the period.
  logic [RptW-1:0] rptCnt, nextRptCnt;
  logic            rptArmed, nextRptArmed;
  logic [RptW-1:0] rptLimit;

  assign rptLimit = rptArmed ? RptPeriodLast : RptDelayLast;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncFf     <= '0;
      state      <= IDLE;
      cnt        <= '0;
      btnLevel   <= 1'b0;
      btnPress   <= 1'b0;
      btnRelease <= 1'b0;
    end else begin
      syncFf     <= {syncFf[0], btnRaw};
      state      <= nextState;
      cnt        <= nextCnt;
      btnLevel   <= nextLevel;
      btnPress   <= nextPress;
      btnRelease <= nextRelease;
    end
  end

`ifdef AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rptCnt   <= '0;
      rptArmed <= 1'b0;
    end else begin
      rptCnt   <= nextRptCnt;
      rptArmed <= nextRptArmed;
    end
  end
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    nextState   = state;
    nextCnt     = cnt;
    nextLevel   = btnLevel;
    nextPress   = 1'b0;
    nextRelease = 1'b0;
`ifdef AUTOREPEAT_EN
    nextRptCnt   = rptCnt;
    nextRptArmed = rptArmed;
`endif

    unique case (state)
      IDLE: begin
        if (btnSync) begin
          nextState = PRESS_WAIT;
          nextCnt   = CntOne;
        end
      end

      PRESS_WAIT: begin
        if (!btnSync) begin
          nextState = IDLE;
          nextCnt   = '0;
        end else if (cnt == CntLast) begin
          nextState = HELD;
          nextCnt   = '0;
          nextLevel = 1'b1;
          nextPress = 1'b1;
`ifdef AUTOREPEAT_EN
          nextRptCnt   = '0;
          nextRptArmed = 1'b0;
`endif
        end else begin
          nextCnt = cnt + CntOne;
        end
      end

      HELD: begin
        if (!btnSync) begin
          nextState = REL_WAIT;
          nextCnt   = CntOne;
        end else begin
`ifdef AUTOREPEAT_EN
          if (rptCnt == rptLimit) begin
            nextPress    = 1'b1;
            nextRptCnt   = '0;
            nextRptArmed = 1'b1;
          end else begin
            nextRptCnt = rptCnt + 1'b1;
          end
`endif
        end
      end

      REL_WAIT: begin
        // The repeat count is left untouched here so a release bounce resumes it.
        if (btnSync) begin
          nextState = HELD;
          nextCnt   = '0;
        end else if (cnt == CntLast) begin
          nextState   = IDLE;
          nextCnt     = '0;
          nextLevel   = 1'b0;
          nextRelease = 1'b1;
`ifdef AUTOREPEAT_EN
          nextRptCnt   = '0;
          nextRptArmed = 1'b0;
`endif
        end else begin
          nextCnt = cnt + CntOne;
        end
      end

      default: begin
        nextState = IDLE;
        nextCnt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: NUM_BTN independent synchronise/debounce channels.
// Optional auto-repeat of btn_press is enabled by defining AUTOREPEAT_EN.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = DEFAULT_NUM_BTN,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : gCh
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) uCh (
      .clk       (clk),
      .rst       (rst),
      .btnRaw    (btn_raw[i]),
      .btnLevel  (btn_level[i]),
      .btnPress  (btn_press[i]),
      .btnRelease(btn_release[i])
    );
  end

endmodule
